// File: rtl/dc_hyper_pkg.sv
// Shared definitions for the hyperbus dual-clock token-ring FIFO.
// Holds depth limits, the statistics counter width and the one-hot check
// used on the write token.
package dc_hyper_pkg;

    localparam int DC_HYPER_MIN_DEPTH = 4;
    localparam int DC_HYPER_MAX_DEPTH = 32;
    localparam int DC_HYPER_CNT_W     = 16;

    // True when exactly one bit of the (zero-extended) token is set.
    function automatic logic onehot_is_valid(input logic [DC_HYPER_MAX_DEPTH-1:0] token);
        int unsigned ones;
        ones = 0;
        for (int k = 0; k < DC_HYPER_MAX_DEPTH; k++) begin
            ones = ones + 32'(token[k]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/dc_onehot_to_bin_hyper.sv
// One-hot to binary converter for the write token.
// The result is only meaningful when the input is one-hot; callers gate on
// that condition themselves.
module dc_onehot_to_bin_hyper #(
    parameter int BUFFER_DEPTH = 8
) (
    input  logic [BUFFER_DEPTH-1:0]         onehot,
    output logic [$clog2(BUFFER_DEPTH)-1:0] bin
);

    localparam int IDX_W = $clog2(BUFFER_DEPTH);

    // OR together the indices of all set bits.
    always_comb begin
        // NOTE: the default assignment ahead of the loop keeps every path driven, so no latch is inferred.
        bin = '0;
        for (int k = 0; k < BUFFER_DEPTH; k++) begin
            if (onehot[k]) begin
                bin = bin | IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/dc_token_ring_writer_hyper.sv
// Write-side stage of the hyperbus dual-clock token-ring FIFO.
// Stores accepted producer words in the slot selected by a one-hot token and
// exports both the slots and the token to the read domain.
// Optional statistics counters are enabled by defining DC_HYPER_WRITER_STATS_EN.
module dc_token_ring_writer_hyper
    import dc_hyper_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic                               full_i,
    output logic                               det_valid_o,
    output logic [BUFFER_DEPTH-1:0]            write_token_o,
    output logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer_o,
    output logic                               token_err_o,
    output logic [DC_HYPER_CNT_W-1:0]          word_cnt_o,
    output logic [DC_HYPER_CNT_W-1:0]          stall_cnt_o
);

    localparam int IDX_W = $clog2(BUFFER_DEPTH);

    if ((BUFFER_DEPTH < DC_HYPER_MIN_DEPTH) || (BUFFER_DEPTH > DC_HYPER_MAX_DEPTH)) begin : g_depth_check
        $error("dc_token_ring_writer_hyper: BUFFER_DEPTH must be in 4..32");
    end

    logic [BUFFER_DEPTH-1:0] token;
    logic [DATA_WIDTH-1:0]   slots [BUFFER_DEPTH];
    logic [IDX_W-1:0]        idx;
    logic                    token_ok;
    logic                    accept;
    logic                    write_en;
    logic                    token_err;

    // Full must block the write in the same cycle, so ready is purely combinational.
    assign ready_o     = ~full_i & ~rst;
    assign accept      = valid_i & ready_o;
    assign det_valid_o = valid_i;

    // A corrupted token has no defined slot, so the write is dropped while the handshake proceeds.
    assign token_ok = onehot_is_valid(DC_HYPER_MAX_DEPTH'(token));
    assign write_en = accept & token_ok;

    dc_onehot_to_bin_hyper #(
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_token_idx (
        .onehot(token),
        .bin   (idx)
    );

    // Advance the token on every accept and latch any loss of one-hotness.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            token     <= BUFFER_DEPTH'(1);
            token_err <= 1'b0;
        end else begin
            if (accept) begin
                token <= {token[BUFFER_DEPTH-2:0], token[BUFFER_DEPTH-1]};
            end
            if (!token_ok) begin
                token_err <= 1'b1;
            end
        end
    end

    // Write the addressed slot; slots are cleared on reset.
    always_ff @(posedge clk) begin
        // NOTE: the slot array is reset because it is exported raw to the read domain, where unknown contents would be visible.
        if (rst) begin
            for (int k = 0; k < BUFFER_DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (write_en) begin
            slots[idx] <= data_i;
        end
    end

    for (genvar k = 0; k < BUFFER_DEPTH; k++) begin : g_flatten
        assign buffer_o[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
    end

    assign write_token_o = token;
    assign token_err_o   = token_err;

`ifdef DC_HYPER_WRITER_STATS_EN
    logic [DC_HYPER_CNT_W-1:0] word_cnt;
    logic [DC_HYPER_CNT_W-1:0] stall_cnt;
    logic                      stall;

    assign stall = valid_i & ~ready_o & ~rst;

    // Saturating counters of accepted words and stalled producer cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && (word_cnt != '1)) begin
                word_cnt <= word_cnt + DC_HYPER_CNT_W'(1);
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + DC_HYPER_CNT_W'(1);
            end
        end
    end

    assign word_cnt_o  = word_cnt;
    assign stall_cnt_o = stall_cnt;
`else
    assign word_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/dc_token_ring_writer_hyper.md
Name: dc_token_ring_writer_hyper

Overview:
Write-side stage of the hyperbus dual-clock token-ring FIFO. It accepts words from the write-domain producer over a valid/ready handshake and stores each word in a register buffer slot selected by a one-hot write token. It exports the buffer and the token to the read domain. It takes the synchronised full indication from the domain-crossing full detector and drives that detector's valid input.

Parameters:
DATA_WIDTH, 32, width of one stored word.
BUFFER_DEPTH, 8, number of slots and width of the one-hot token; legal range 4..32. Values below 4 are a compile-time error.

Ports:
clk  input  1  write-domain clock.
rst  input  1  synchronous, active-high reset.
data_i  input  DATA_WIDTH  producer data.
valid_i  input  1  producer has a word.
ready_o  output  1  block can accept a word this cycle.
full_i  input  1  full flag from the full detector, already synchronised to clk.
det_valid_o  output  1  valid to the full detector.
write_token_o  output  BUFFER_DEPTH  one-hot write pointer, sent to the read domain.
buffer_o  output  BUFFER_DEPTH*DATA_WIDTH  flattened slot contents; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
token_err_o  output  1  sticky flag: write token is not one-hot.
word_cnt_o  output  16  accepted-word count (optional feature).
stall_cnt_o  output  16  stalled-cycle count (optional feature).

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset rst is synchronous and active-high.
  - Reset values: write_token_o = 1 (bit 0 set); every buffer slot = 0; token_err_o = 0; word_cnt_o = 0; stall_cnt_o = 0.
- Handshake (combinational):
  - ready_o = ~full_i & ~rst.
  - accept = valid_i & ready_o.
  - det_valid_o = valid_i.
- On accept (clock edge):
  - Slot idx(write_token) <= data_i.
  - write_token rotates left by one; bit BUFFER_DEPTH-1 wraps to bit 0.
  - The slot write and the token advance happen on the same edge.
  - Timing: the written word is visible on buffer_o, and the new token on write_token_o, one cycle after the accept edge.
  - A slot's contents are stable from the cycle after its write until the slot is written again.
- No accept (valid_i=0 or full_i=1):
  - Token and buffer hold.
  - The producer must hold data_i and valid_i until accepted; this is not checked.
- Wrap-around: after BUFFER_DEPTH accepts the token returns to bit 0. Overrun protection relies entirely on full_i.
- Full asserting during valid_i: ready_o drops in the same cycle and no write occurs. This combinational path is required.
- Token integrity:
  - If the registered token is not exactly one-hot, token_err_o sets and stays set until rst.
  - While the token is invalid, writes are suppressed: idx is undefined and no slot is modified. ready_o is unaffected.
- Reset mid-operation:
  - rst=1 forces ready_o=0 in the same cycle.
  - All state takes its reset value on the next edge.
  - The read domain must be reset by the same system reset event. The block does not coordinate this.

Optional Feature:
Macro: DC_HYPER_WRITER_STATS_EN.
- Defined:
  - word_cnt_o increments on each accept.
  - stall_cnt_o increments on each cycle with valid_i & ~ready_o & ~rst.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: both ports are present and tied to 0, and no counter flops are synthesised.

Decomposition:
- Shared package dc_hyper_pkg holds:
  - constant DC_HYPER_MIN_DEPTH = 4;
  - constant DC_HYPER_CNT_W = 16;
  - function onehot_is_valid(token).
- One sub-module: dc_onehot_to_bin_hyper (parameter BUFFER_DEPTH). It converts the one-hot token to a binary slot index, with output width $clog2(BUFFER_DEPTH).

Test Plan:
1. rst for 2 cycles, then release -> write_token_o=8'h01, buffer_o all 0, ready_o=1 with full_i=0, token_err_o=0.
2. Back-to-back accepts of data 32'hA0..32'hA7 with full_i=0 -> slots 0..7 hold A0..A7 and the token returns to 8'h01. A ninth word 32'hA8 lands in slot 0.
3. valid_i=1, data 32'h55, full_i=1 for 3 cycles, then 0 -> ready_o=0 for those 3 cycles and the token is unchanged. Accept occurs in the 4th cycle; stall_cnt_o=3 with the macro defined, 0 without.
4. Force the token register to 8'h03 -> token_err_o=1 next cycle, no slot changes on subsequent valid_i, and token_err_o stays 1 until rst.
5. rst asserted in the middle of a burst after 3 accepts -> ready_o=0 in the same cycle; next edge gives token=8'h01, all slots 0, word_cnt_o=0.
6. With macro defined, 70000 accepts (full_i toggling) -> word_cnt_o saturates at 16'hFFFF and does not wrap.
